egg_timer_control: RTL and testbench
====================================

Name: egg_timer_control

Overview:
Control FSM and time-base for the egg timer. Drives the per-digit control strobes of the BCD digit registers (set, start, decrement, zero, done, wrap) and consumes the digits' current values. Generates the 1-second tick, the inter-digit borrow chain and the alarm. Sits between the debounced button logic and the MM:SS digit register bank.

Parameters:
DIGITS, 4, number of BCD digits; digit 0 = seconds units, digit 3 = minutes tens
TICK_DIV, 50000000, clk cycles per timer tick (1 s); minimum 2
DIV_W, 26, prescaler width; must satisfy 2^DIV_W >= TICK_DIV
ALARM_TICKS, 30, DONE auto-clear time in ticks (used only with ALARM_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
set_btn  input  1  one-cycle pulse; toggles set mode
start_btn  input  1  one-cycle pulse; start / pause / resume / acknowledge
set_load  input  1  one-cycle pulse; load the selected digit in SET
digit_sel  input  2  digit selected for loading (0..DIGITS-1)
running  input  4*DIGITS  current digit values, digit k at [4k+3:4k]
is_setting  output  DIGITS  per-digit load strobe
is_starting  output  1  one-cycle pulse on entry to RUN from IDLE or SET
is_decrement  output  DIGITS  per-digit decrement strobe
is_zero  output  DIGITS  digit k value == 0
is_done  output  1  all digits == 0
wrap  output  4*DIGITS  per-digit borrow reload value
alarm  output  1  high while in DONE
state  output  3  IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4

Behaviour:
- Reset (async): state=IDLE, prescaler=0, tick=0; all outputs 0 except is_zero/is_done/wrap, which stay combinational on running and the constant wrap values.
- wrap is constant: digits 0 and 2 = 9, digit 1 = 5, digit 3 = 9. Digits with index >= 4 = 9.
- is_zero[k] = (running[k]==0); is_done = &is_zero.
- Prescaler counts only in RUN, holds in PAUSE and clears in every other state. It wraps at TICK_DIV-1, and the wrap registers a one-cycle tick. A pending tick is discarded when RUN is left.
- is_decrement[k] = tick & RUN & !is_done & (all digits 0..k-1 zero); digit 0 needs only tick. This combinational output in the tick cycle makes the digit registers update on the next edge.
- is_setting[k] = (state==SET) & set_load & (digit_sel==k) for one cycle. Out-of-range digit_sel: no strobe.
- Transitions. Buttons are evaluated only in the listed states. When both fire in the same cycle, start_btn wins, except in DONE.
  - IDLE: start_btn & !is_done -> RUN (is_starting pulse). start_btn & is_done -> stays IDLE. set_btn -> SET.
  - SET: start_btn & !is_done -> RUN (is_starting pulse). start_btn & is_done -> IDLE. set_btn -> IDLE.
  - RUN: is_done -> DONE, checked before tick and button. Otherwise start_btn -> PAUSE.
  - PAUSE: start_btn -> RUN (no is_starting). set_btn -> SET.
  - DONE: start_btn or set_btn -> IDLE.
- alarm = (state==DONE), registered with state.
- Reset mid-RUN: returns to IDLE immediately. The prescaler and any pending tick are lost.

Optional Feature:
ALARM_TIMEOUT_EN
- Defined: DONE keeps a tick counter that runs the prescaler as in RUN. After ALARM_TICKS ticks, DONE -> IDLE. A button in DONE still exits immediately.
- Undefined: DONE is held until a button press. No alarm counter is synthesised.

Test Plan:
- TICK_DIV=4, running=0x0100 (01:00), start_btn in IDLE -> is_starting one cycle, state=RUN. First tick 4 cycles later -> is_decrement=4'b0111 for exactly one cycle; wrap digits 0..2 = 9,5,9.
- running=0x0000 in IDLE, start_btn -> state stays IDLE, is_starting=0. set_btn then start_btn in SET -> IDLE.
- SET, digit_sel=2, set_load -> is_setting=4'b0100 for one cycle. digit_sel=3 with DIGITS=3 -> is_setting=0.
- RUN with prescaler at 2, start_btn -> PAUSE. Hold 10 cycles, then start_btn -> next tick arrives exactly 1 cycle after resume, and is_starting stays 0.
- RUN, running becomes 0x0000 -> next cycle state=DONE, alarm=1, no is_decrement. set_btn and start_btn together -> IDLE, alarm=0.
- Reset asserted mid-RUN between clock edges -> state=IDLE and alarm=0 immediately. With ALARM_TIMEOUT_EN, ALARM_TICKS=2 and TICK_DIV=4: DONE -> IDLE after 8 cycles.

Source files
------------

// File: rtl/egg_timer_control_if.sv
// Signal bundle between the button/digit side and the egg timer control FSM.
// master drives buttons and digit values; slave is the control block.
interface egg_timer_control_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  set_btn;
    logic                  start_btn;
    logic                  set_load;
    logic [1:0]            digit_sel;
    logic [4*DIGITS-1:0]   running;
    logic [DIGITS-1:0]     is_setting;
    logic                  is_starting;
    logic [DIGITS-1:0]     is_decrement;
    logic [DIGITS-1:0]     is_zero;
    logic                  is_done;
    logic [4*DIGITS-1:0]   wrap;
    logic                  alarm;
    logic [2:0]            state;

    modport master (
        output set_btn, start_btn, set_load, digit_sel, running,
        input  is_setting, is_starting, is_decrement, is_zero, is_done, wrap, alarm, state
    );

    modport slave (
        input  set_btn, start_btn, set_load, digit_sel, running,
        output is_setting, is_starting, is_decrement, is_zero, is_done, wrap, alarm, state
    );
endinterface

// File: rtl/egg_timer_control.sv
// Egg timer control FSM, 1 s time base and digit borrow chain.
// Define ALARM_TIMEOUT_EN to auto-clear DONE after ALARM_TICKS ticks.
module egg_timer_control #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned ALARM_TICKS = 30
) (
    input logic                clk,
    input logic                reset,
    egg_timer_control_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSet   = 3'd1,
        StRun   = 3'd2,
        StPause = 3'd3,
        StDone  = 3'd4
    } state_t;

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 2");
    end
    if ((64'd1 << DIV_W) < 64'(TICK_DIV)) begin : g_bad_div_w
        $error("DIV_W too narrow for TICK_DIV");
    end
    if (ALARM_TICKS < 1) begin : g_bad_alarm_ticks
        $error("ALARM_TICKS must be at least 1");
    end

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic               tick_q, tick_d;
    logic               starting_q, starting_d;
    logic               presc_last;
    logic [DIGITS-1:0]  zero;
    logic               done;

`ifdef ALARM_TIMEOUT_EN
    localparam int unsigned ALARM_W = (ALARM_TICKS < 2) ? 1 : $clog2(ALARM_TICKS + 1);
    logic [ALARM_W-1:0] alarm_cnt_q, alarm_cnt_d;
    logic               alarm_expire;
`endif

    assign presc_last = (presc_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        zero = '0;
        bus.wrap = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            zero[k] = (bus.running[4*k +: 4] == 4'd0);
            bus.wrap[4*k +: 4] = (k == 1) ? 4'd5 : 4'd9;
        end
        done = &zero;
    end

`ifdef ALARM_TIMEOUT_EN
    assign alarm_expire = presc_last && (alarm_cnt_q == ALARM_W'(ALARM_TICKS - 1));
`endif

    // Next state: start_btn takes priority over set_btn except in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start_btn) begin
                    if (!done) state_d = StRun;
                end else if (bus.set_btn) begin
                    state_d = StSet;
                end
            end
            StSet: begin
                if (bus.start_btn) state_d = done ? StIdle : StRun;
                else if (bus.set_btn) state_d = StIdle;
            end
            StRun: begin
                if (done) state_d = StDone;
                else if (bus.start_btn) state_d = StPause;
            end
            StPause: begin
                if (bus.start_btn) state_d = StRun;
                else if (bus.set_btn) state_d = StSet;
            end
            StDone: begin
                if (bus.start_btn || bus.set_btn) state_d = StIdle;
`ifdef ALARM_TIMEOUT_EN
                else if (alarm_expire) state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Prescaler runs in RUN (and DONE with the timeout), holds in PAUSE.
    always_comb begin
        presc_d = '0;
`ifdef ALARM_TIMEOUT_EN
        if (state_q == StRun || state_q == StDone) begin
`else
        if (state_q == StRun) begin
`endif
            presc_d = presc_last ? '0 : presc_q + DIV_W'(1);
        end else if (state_q == StPause) begin
            presc_d = presc_q;
        end
        if (state_q == StRun && state_d == StDone) presc_d = '0;
        // A tick registered on the edge that leaves RUN would be stale.
        tick_d = (state_q == StRun) && (state_d == StRun) && presc_last;
        starting_d = (state_d == StRun) && (state_q == StIdle || state_q == StSet);
    end

`ifdef ALARM_TIMEOUT_EN
    always_comb begin
        alarm_cnt_d = '0;
        if (state_q == StDone && state_d == StDone) begin
            alarm_cnt_d = presc_last ? alarm_cnt_q + ALARM_W'(1) : alarm_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) alarm_cnt_q <= '0;
        else       alarm_cnt_q <= alarm_cnt_d;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            starting_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            starting_q <= starting_d;
        end
    end

    // Borrow chain: digit k decrements when all lower digits are already zero.
    always_comb begin
        logic lower_zero;
        logic dec_en;
        lower_zero = 1'b1;
        dec_en = tick_q && (state_q == StRun) && !done;
        bus.is_decrement = '0;
        bus.is_setting = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            bus.is_decrement[k] = dec_en && lower_zero;
            lower_zero = lower_zero && zero[k];
            bus.is_setting[k] = (state_q == StSet) && bus.set_load &&
                                (32'(bus.digit_sel) == k);
        end
    end

    assign bus.is_zero     = zero;
    assign bus.is_done     = done;
    assign bus.is_starting = starting_q;
    assign bus.alarm       = (state_q == StDone);
    assign bus.state       = state_q;

endmodule

// File: tb/tb_egg_timer_control.sv
// Directed bench for egg_timer_control: vector table plus multi-cycle corner sequences.
module tb_egg_timer_control;

    localparam logic [15:0] R  = 16'h0100;
    localparam logic [15:0] R2 = 16'h0010;

    typedef struct {
        logic        set_btn;
        logic        start_btn;
        logic        set_load;
        logic [1:0]  sel;
        logic [15:0] run;
        logic [2:0]  st;
        logic        starting;
        logic [3:0]  dec;
        logic [3:0]  setl;
        logic        alarm;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    egg_timer_control_if #(.DIGITS(4)) bus ();
    egg_timer_control_if #(.DIGITS(3)) bus3 ();

    egg_timer_control #(
        .DIGITS(4), .TICK_DIV(4), .DIV_W(3), .ALARM_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    egg_timer_control #(
        .DIGITS(3), .TICK_DIV(4), .DIV_W(3), .ALARM_TICKS(2)
    ) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int unsigned sb, stb, sl, sel, run,
                                input int unsigned st, starting, dec, setl, alarm);
        vec_t v;
        v.set_btn   = 1'(sb);
        v.start_btn = 1'(stb);
        v.set_load  = 1'(sl);
        v.sel       = 2'(sel);
        v.run       = 16'(run);
        v.st        = 3'(st);
        v.starting  = 1'(starting);
        v.dec       = 4'(dec);
        v.setl      = 4'(setl);
        v.alarm     = 1'(alarm);
        return v;
    endfunction

    function automatic logic [3:0] zmask(input logic [15:0] r);
        logic [3:0] z;
        for (int k = 0; k < 4; k++) z[k] = (r[4*k +: 4] == 4'h0);
        return z;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; checks mid-cycle, returns just after the next edge.
    task automatic apply(input string name, input vec_t v);
        logic [17:0] act, exp;
        bus.set_btn   = v.set_btn;
        bus.start_btn = v.start_btn;
        bus.set_load  = v.set_load;
        bus.digit_sel = v.sel;
        bus.running   = v.run;
        @(negedge clk);
        act = {bus.state, bus.is_starting, bus.is_decrement, bus.is_setting, bus.alarm,
               bus.is_zero, bus.is_done};
        exp = {v.st, v.starting, v.dec, v.setl, v.alarm, zmask(v.run), &zmask(v.run)};
        check(name, 32'(act), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.set_btn = 0; bus.start_btn = 0; bus.set_load = 0; bus.digit_sel = 0;
        bus.running = R;
        bus3.set_btn = 0; bus3.start_btn = 0; bus3.set_load = 0; bus3.digit_sel = 0;
        bus3.running = 12'h100;

        //          sb stb sl sel run  st strt dec     setl alarm
        vecs.push_back(mk(0, 0, 0, 0, R,  0, 0, 0,      0, 0));
        vecs.push_back(mk(0, 1, 0, 0, R,  0, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R,  2, 1, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R,  2, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R,  2, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R,  2, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R,  2, 0, 4'b0111, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R,  2, 0, 0,      0, 0));
        vecs.push_back(mk(0, 1, 0, 0, R,  2, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R,  3, 0, 0,      0, 0));
        vecs.push_back(mk(0, 1, 0, 0, R,  3, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R,  2, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R,  2, 0, 4'b0111, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  2, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  4, 0, 0,      0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0,  4, 0, 0,      0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,      0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 1, 2, 0,  1, 0, 0, 4'b0100, 0));
        vecs.push_back(mk(0, 0, 0, 2, 0,  1, 0, 0,      0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0,      0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0,      0, 0));
        vecs.push_back(mk(1, 1, 0, 0, R,  1, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R,  2, 1, 0,      0, 0));
        vecs.push_back(mk(0, 1, 0, 0, R,  2, 0, 0,      0, 0));
        vecs.push_back(mk(1, 0, 0, 0, R,  3, 0, 0,      0, 0));
        vecs.push_back(mk(1, 0, 0, 0, R,  1, 0, 0,      0, 0));
        vecs.push_back(mk(0, 1, 0, 0, R2, 0, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R2, 2, 1, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R2, 2, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 1, 1, R2, 2, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R2, 2, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R2, 2, 0, 4'b0011, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, R2, 2, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R2, 3, 0, 0,      0, 0));
        vecs.push_back(mk(1, 0, 0, 0, R2, 3, 0, 0,      0, 0));
        vecs.push_back(mk(1, 0, 0, 0, R2, 1, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R2, 0, 0, 0,      0, 0));

        // Reset state and constant wrap values
        #3;
        check("reset_state", 32'({bus.state, bus.alarm, bus.is_starting, bus.is_decrement,
                                  bus.is_setting}), 32'(0));
        check("wrap4", 32'(bus.wrap), 32'h9959);
        check("wrap3", 32'(bus3.wrap), 32'h959);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

        // Pause with prescaler at 2, hold 10 cycles, tick lands one cycle after resume
        apply("pz_start", mk(0, 1, 0, 0, R, 0, 0, 0, 0, 0));
        apply("pz_c0",    mk(0, 0, 0, 0, R, 2, 1, 0, 0, 0));
        apply("pz_c1",    mk(0, 0, 0, 0, R, 2, 0, 0, 0, 0));
        apply("pz_pause", mk(0, 1, 0, 0, R, 2, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) apply($sformatf("pz_hold%0d", i),
                                           mk(0, 0, 0, 0, R, 3, 0, 0, 0, 0));
        apply("pz_resume", mk(0, 1, 0, 0, R, 3, 0, 0, 0, 0));
        apply("pz_run0",   mk(0, 0, 0, 0, R, 2, 0, 0, 0, 0));
        apply("pz_tick",   mk(0, 0, 0, 0, R, 2, 0, 4'b0111, 0, 0));

        // Asynchronous reset mid-RUN
        #2;
        reset = 1'b1;
        #1;
        check("rst_run_state", 32'({bus.state, bus.alarm}), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply("rr_start", mk(0, 1, 0, 0, R, 0, 0, 0, 0, 0));
        apply("rr_c0",    mk(0, 0, 0, 0, R, 2, 1, 0, 0, 0));
        for (int i = 1; i < 4; i++) apply($sformatf("rr_c%0d", i),
                                          mk(0, 0, 0, 0, R, 2, 0, 0, 0, 0));
        apply("rr_tick",  mk(0, 0, 0, 0, R, 2, 0, 4'b0111, 0, 0));
        apply("rr_zero",  mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        apply("rr_done",  mk(0, 0, 0, 0, 0, 4, 0, 0, 0, 1));

        // Asynchronous reset while the alarm is up
        #2;
        reset = 1'b1;
        #1;
        check("rst_done_state", 32'({bus.state, bus.alarm}), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Three-digit build: digit_sel 3 selects nothing
        bus3.set_btn = 1'b1;
        @(posedge clk);
        #1;
        bus3.set_btn = 1'b0;
        bus3.set_load = 1'b1;
        bus3.digit_sel = 2'd2;
        @(negedge clk);
        check("d3_state", 32'(bus3.state), 32'(1));
        check("d3_sel2", 32'(bus3.is_setting), 32'(3'b100));
        @(posedge clk);
        #1;
        bus3.digit_sel = 2'd3;
        @(negedge clk);
        check("d3_sel3", 32'(bus3.is_setting), 32'(0));
        @(posedge clk);
        #1;
        bus3.set_load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
